uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port tx_data, input, 8 bits: byte to transmit (driven from the data memory UART TX byte).
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data valid this cycle.
REQ-007 SHALL have port tx_ready, output, 1 bit: holding buffer empty; a byte is accepted only when tx_valid and tx_ready are both 1 on a rising edge.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: frame in progress or holding buffer occupied.

Function
REQ-010 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only with UART_TX_PARITY_EN.
REQ-011 SHALL hold one byte in a holding register plus one in a shift register: accept into the holding register, move it to the shift register on entering START.
REQ-012 SHALL deassert tx_ready the cycle after acceptance and reassert it the cycle after the holding register transfers to the shift register.
REQ-013 SHALL, from IDLE with a byte accepted on edge N, drive tx=0 (start bit) from edge N+1.
REQ-014 SHALL hold every bit exactly CLKS_PER_BIT cycles using a baud counter of width $clog2(CLKS_PER_BIT), reloaded at each bit boundary.
REQ-015 SHALL send data bits LSB first in DATA, using a 3-bit bit index that wraps 7->0 when leaving DATA.
REQ-016 SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles in STOP.
REQ-017 SHALL, at the end of STOP, go to START if the holding register is full, giving back-to-back frames with no idle gap; otherwise it SHALL go to IDLE.
REQ-018 SHALL accept a byte on the same edge the FSM leaves STOP and include it in the back-to-back decision.
REQ-019 SHALL ignore tx_valid while tx_ready=0: no overwrite and no error.
REQ-020 SHALL drive busy=1 whenever state!=IDLE or the holding register is full.
REQ-021 SHALL register tx, so it is glitch-free and never combinational from inputs.

Reset
REQ-022 SHALL, on rst=1 at a rising edge, set state=IDLE, tx=1, tx_ready=1, busy=0, baud counter=0, bit index=0, and holding register empty.
REQ-023 SHALL let rst abort a frame mid-operation: tx returns to 1 on the next edge and the partial frame and buffered byte are discarded.
REQ-024 SHALL give rst priority over a simultaneous tx_valid, so the byte is not accepted.

Configuration
REQ-025 SHALL, with macro UART_TX_PARITY_EN defined, insert one even-parity bit (XOR of the 8 data bits) after DATA, lasting CLKS_PER_BIT cycles.
REQ-026 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and its logic entirely; the frame is 1+8+STOP_BITS bits.

Structure
REQ-027 SHALL place the FSM state typedef/encoding and the default CLKS_PER_BIT constant in the shared core package (core_pkg).
REQ-028 SHALL contain one natural sub-module, uart_baud_gen (counter plus bit_tick strobe, restartable by the FSM); the FSM, holding register and shifter stay in uart_tx.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-029 SHALL check: reset, then 0x55 accepted at edge 0 -> tx low on edges 1-4, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; tx_ready=1 at edge 6 or later.
REQ-030 SHALL check: 0xA5 then 0x3C offered as soon as tx_ready=1 -> second start bit immediately follows first stop bit (no idle cycle); busy stays 1 for 80 cycles.
REQ-031 SHALL check: third byte 0xFF with tx_valid held while tx_ready=0 -> not accepted until the buffer empties; exactly three frames appear, in order.
REQ-032 SHALL check: rst asserted at cycle 17 of a 0x81 frame -> tx=1, tx_ready=1, busy=0 next edge; no further transitions.
REQ-033 SHALL check: UART_TX_PARITY_EN defined with 0x07 -> parity bit 1 after bit 7; with 0x03 -> parity bit 0; frame is 44 cycles.
REQ-034 SHALL check: STOP_BITS=2 with 0x00 -> stop level high for 8 cycles before IDLE.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and constants for the UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package core_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200
  localparam int unsigned UART_DATA_W               = 8;
  localparam int unsigned UART_IDX_W                = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

`ifdef UART_TX_PARITY_EN
  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] b);
    return ^b;
  endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick_c pulses on the last cycle of each bit period.
// Held at zero while restart is high so the first bit after it is full length.
module uart_baud_gen
  import core_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick_c
);

  localparam int unsigned          CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    bit_tick_c = (cnt_q == CNT_LAST) && !restart;
    cnt_d      = cnt_q + CNT_W'(1);
    if (restart || bit_tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding buffer feeding a frame serializer.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx
  import core_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   busy
);

  localparam logic [UART_IDX_W-1:0] DATA_LAST = UART_IDX_W'(UART_DATA_W - 1);
  localparam logic [UART_IDX_W-1:0] STOP_LAST = UART_IDX_W'(STOP_BITS - 1);

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic                   tx_d, tx_ready_d, busy_d;
  logic                   accept_c;
  logic                   bit_tick_c;
  logic                   baud_restart_c;

  assign baud_restart_c = (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .restart   (baud_restart_c),
    .bit_tick_c(bit_tick_c)
  );

  // Next-state, buffer handshake and registered line level.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    tx_ready_d  = tx_ready;
    accept_c    = tx_valid && tx_ready;

    if (accept_c) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      tx_ready_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d     = START;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          tx_ready_d  = 1'b1;
        end
      end
      START: begin
        if (bit_tick_c) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_tick_c) begin
          bit_idx_d = bit_idx_q + UART_IDX_W'(1);
          if (bit_idx_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick_c) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // bit_idx counts stop bits here; a byte arriving on the final edge still chains.
        if (bit_tick_c) begin
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            if (hold_full_q) begin
              state_d     = START;
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              tx_ready_d  = 1'b1;
            end else if (accept_c) begin
              state_d     = START;
              shift_d     = tx_data;
              hold_full_d = 1'b0;
              tx_ready_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + UART_IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = even_parity(shift_d);
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE) || hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      tx          <= 1'b1;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx          <= tx_d;
      tx_ready    <= tx_ready_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx against a frame-level line model.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LOG_N = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       sel;
  logic       ready1, tx1, busy1;
  logic       ready2, tx2, busy2;
  logic       mon_ready, mon_tx, mon_busy;
  logic       valid1, valid2;

  always #5 clk = ~clk;

  assign valid1    = valid & ~sel;
  assign valid2    = valid & sel;
  assign mon_ready = sel ? ready2 : ready1;
  assign mon_tx    = sel ? tx2 : tx1;
  assign mon_busy  = sel ? busy2 : busy1;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid1),
    .tx_ready(ready1), .tx(tx1), .busy(busy1)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(data), .tx_valid(valid2),
    .tx_ready(ready2), .tx(tx2), .busy(busy2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line model: a frame is start(0), 8 data bits LSB first, optional even parity, stop(1)s.
  function automatic int frame_cycles(input int stop_bits);
    return (1 + 8 + PAR_BITS + stop_bits) * CPB;
  endfunction

  function automatic logic frame_level(input logic [7:0] b, input int pos);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (PAR_BITS == 1 && pos == 9) return (ones % 2) == 1;
    return 1'b1;
  endfunction

  logic [7:0] byte_q[$];
  int         offer_q[$];
  int         acc_t[$];
  int         start_t[$];
  logic [7:0] acc_b[$];
  logic       tx_log[LOG_N];
  logic       busy_log[LOG_N];
  logic       ready_log[LOG_N];
  int         t_end;

  task automatic do_reset();
    valid = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
  endtask

  // Offers byte_q[i] from time offer_q[i] until accepted, logs the line, then
  // replays the log against the model.
  task automatic run_stream(input int cycles);
    int   t, idx, prev_end, st, f, n;
    logic pre, exp_tx, exp_busy;
    t = 0; idx = 0; prev_end = -1000;
    f = frame_cycles(sel ? 2 : 1);
    n = byte_q.size();
    acc_t.delete(); start_t.delete(); acc_b.delete();
    tx_log[0] = mon_tx; busy_log[0] = mon_busy; ready_log[0] = mon_ready;
    for (int c = 0; c < cycles && t < LOG_N - 1; c++) begin
      if (idx < n && t >= offer_q[idx]) begin
        valid = 1'b1;
        data  = mon_ready ? byte_q[idx] : 8'($urandom);
      end else begin
        valid = 1'b0;
        data  = 8'($urandom);
      end
      pre = valid && mon_ready;
      @(posedge clk); #1;
      t++;
      tx_log[t] = mon_tx; busy_log[t] = mon_busy; ready_log[t] = mon_ready;
      if (pre) begin
        st = (t <= prev_end) ? prev_end : t + 1;
        if (t != prev_end) check($sformatf("ready_drop@%0d", t), 32'(mon_ready), 32'd0);
        acc_t.push_back(t); start_t.push_back(st); acc_b.push_back(byte_q[idx]);
        prev_end = st + f;
        idx++;
      end
    end
    valid = 1'b0;
    t_end = t;
    check("all_accepted", 32'(idx), 32'(n));
    for (int s = 1; s <= t; s++) begin
      exp_tx = 1'b1; exp_busy = 1'b0;
      for (int j = 0; j < acc_t.size(); j++) begin
        if (acc_t[j] <= s && s < start_t[j] + f) exp_busy = 1'b1;
        if (start_t[j] <= s && s < start_t[j] + f)
          exp_tx = frame_level(acc_b[j], (s - start_t[j]) / CPB);
      end
      check($sformatf("tx@%0d", s), 32'(tx_log[s]), 32'(exp_tx));
      check($sformatf("busy@%0d", s), 32'(busy_log[s]), 32'(exp_busy));
    end
  endtask

  function automatic int first_low();
    for (int s = 1; s <= t_end; s++) if (tx_log[s] == 1'b0) return s;
    return -1;
  endfunction

  function automatic int last_low();
    for (int s = t_end; s >= 1; s--) if (tx_log[s] == 1'b0) return s;
    return -1;
  endfunction

  function automatic int first_idle_after(input int from);
    for (int s = from + 1; s <= t_end; s++) if (busy_log[s] == 1'b0) return s;
    return -1;
  endfunction

  initial begin
    int run, best, a, s0, s1, off, n;
    sel = 1'b0; valid = 1'b0; data = 8'h00; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",     32'(tx1),    32'd1);
    check("rst_ready",  32'(ready1), 32'd1);
    check("rst_busy",   32'(busy1),  32'd0);
    check("rst_tx2",    32'(tx2),    32'd1);
    check("rst_busy2",  32'(busy2),  32'd0);
    rst = 1'b0;

    // Single 0x55 frame; buffer frees well before edge 6.
    do_reset();
    byte_q = '{8'h55}; offer_q = '{0};
    run_stream(60);
    a = acc_t[0];
    check("ready_after_6", 32'(ready_log[a + 6]), 32'd1);

    // Two bytes back to back: busy continuous across both frames.
    do_reset();
    byte_q = '{8'hA5, 8'h3C}; offer_q = '{0, 0};
    run_stream(120);
    run = 0; best = 0;
    for (int s = 1; s <= t_end; s++) begin
      run  = busy_log[s] ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    check("busy_run_ge80", 32'(best >= 80), 32'd1);

    // Third byte held valid (junk data while not ready) until the buffer empties.
    do_reset();
    byte_q = '{8'hA5, 8'h3C, 8'hFF}; offer_q = '{0, 0, 0};
    run_stream(170);
    check("three_frames", 32'(acc_t.size()), 32'd3);

    // Second byte offered so it lands on the edge the first frame ends.
    do_reset();
    byte_q = '{8'h96, 8'h4B}; offer_q = '{0, 1 + frame_cycles(1)};
    run_stream(120);

    // Reset mid-frame, with a simultaneous valid byte that must be dropped.
    do_reset();
    valid = 1'b1; data = 8'h81;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    check("pre_abort_tx", 32'(tx1), 32'(frame_level(8'h81, 3)));
    rst = 1'b1; valid = 1'b1; data = 8'hC3;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    check("abort_tx",    32'(tx1),    32'd1);
    check("abort_ready", 32'(ready1), 32'd1);
    check("abort_busy",  32'(busy1),  32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check($sformatf("quiet_tx@%0d", i),   32'(tx1),   32'd1);
      check($sformatf("quiet_busy@%0d", i), 32'(busy1), 32'd0);
    end

    // Parity bit and frame length for 0x07 and 0x03.
    do_reset();
    byte_q = '{8'h07}; offer_q = '{0};
    run_stream(70);
    s0 = first_low();
    s1 = first_idle_after(s0);
    check("frame_len_07", 32'(s1 - s0), 32'((1 + 8 + PAR_BITS + 1) * CPB));
    check("parity_07", 32'(tx_log[s0 + 9 * CPB + 1]), 32'(frame_level(8'h07, 9)));
    do_reset();
    byte_q = '{8'h03}; offer_q = '{0};
    run_stream(70);
    s0 = first_low();
    check("parity_03", 32'(tx_log[s0 + 9 * CPB + 1]), 32'(frame_level(8'h03, 9)));

    // Two stop bits: line high for 2*CPB cycles before idle.
    sel = 1'b1;
    do_reset();
    byte_q = '{8'h00}; offer_q = '{0};
    run_stream(80);
    s0 = last_low();
    s1 = first_idle_after(s0);
    check("stop2_len", 32'(s1 - s0 - 1), 32'(2 * CPB));

    // Random bytes with random offer gaps on both stop-bit variants.
    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 1);
      do_reset();
      n = sel ? 6 : 12;
      byte_q.delete(); offer_q.delete();
      off = 0;
      for (int i = 0; i < n; i++) begin
        off += $urandom_range(0, 50);
        byte_q.push_back(8'($urandom));
        offer_q.push_back(off);
      end
      run_stream(off + (n + 1) * frame_cycles(2) + 20);
    end
    sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
